// File: rtl/ahb_ram_slave.sv
// AHB-Lite slave for the data RAM region: lane writes, configurable wait states, two-cycle ERROR.
// Optional build macro: PROT_CHECK_EN (rejects opcode-fetch accesses, hprot[0]=0).
module ahb_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [7:0]  BASE_TAG    = 8'hB0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned OFS_LSB = ADDR_WIDTH + 2;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    logic [31:0]           mem [DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [3:0]            be_q;
    logic                  pend_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  accept_c;
    logic                  err_c;
    logic [3:0]            be_c;
    logic [ADDR_WIDTH-1:0] waddr_c;
    logic                  wr_en_c;
    logic [31:0]           rd_fwd_c;
    logic                  unused_c;

    assign accept_c = hsel && htrans[1] && hready;
    assign waddr_c  = haddr[ADDR_WIDTH+1:2];
    assign wr_en_c  = pend_q && write_q && !hreset;
    assign unused_c = ^{htrans[0], hprot};

    // Address-phase legality: region tag, in-range offset, size and alignment
    always_comb begin
        err_c = 1'b0;
        if (haddr[31:24] != BASE_TAG) err_c = 1'b1;
        if ((haddr[23:0] >> OFS_LSB) != 24'd0) err_c = 1'b1;
        if (hsize > 3'b010) err_c = 1'b1;
        if (hsize == 3'b001 && haddr[0]) err_c = 1'b1;
        if (hsize == 3'b010 && haddr[1:0] != 2'b00) err_c = 1'b1;
`ifdef PROT_CHECK_EN
        if (!hprot[0]) err_c = 1'b1;
`endif
    end

    always_comb begin
        case (hsize)
            3'b000:  be_c = 4'b0001 << haddr[1:0];
            3'b001:  be_c = haddr[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
    end

    // Zero-wait reads may target the word a write is committing on this same edge
    always_comb begin
        rd_fwd_c = mem[waddr_c];
        if (wr_en_c && addr_q == waddr_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) rd_fwd_c[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (wr_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[addr_q][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 32'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            be_q      <= 4'd0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pend_q <= 1'b0;
            hrdata <= 32'd0;
            case (state)
                // ERR2 is a completion cycle, so a new address phase may be taken there too
                ST_IDLE, ST_ERR2: begin
                    state     <= ST_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    if (accept_c) begin
                        addr_q  <= waddr_c;
                        write_q <= hwrite;
                        be_q    <= be_c;
                        if (err_c) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else if (WAIT_STATES != 0) begin
                            state     <= ST_WAIT;
                            hreadyout <= 1'b0;
                            cnt_q     <= CNT_W'(WAIT_STATES - 1);
                        end else begin
                            pend_q <= 1'b1;
                            if (!hwrite) hrdata <= rd_fwd_c;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        pend_q    <= 1'b1;
                        if (!write_q) hrdata <= mem[addr_q];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
AHB-Lite slave fronting the data RAM region (haddr[31:24] == 8'hB0), directly downstream of the core's AHB master glue. It accepts pipelined address/data phases and handles byte, halfword and word lane writes. It inserts a configurable number of wait states and returns a two-cycle ERROR response for illegal transfers. Read data is returned as the full little-endian word; the master extracts and extends the bytes.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words (default 4 KB)
WAIT_STATES, 1, hreadyout-low cycles inserted in each OKAY data phase (0..7)
BASE_TAG, 8'hB0, required value of haddr[31:24]

Ports:
hclk  input  1  clock, all logic on rising edge
hreset  input  1  synchronous active-high reset
hsel  input  1  slave select from address decoder
haddr  input  32  byte address
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1 = write
hsize  input  3  000 byte, 001 half, 010 word
hprot  input  4  protection; bit0 = data access
hwdata  input  32  write data, valid in data phase
hready  input  1  bus hready; address phase valid only when high
hrdata  output  32  read data, valid when hreadyout=1 in read data phase
hreadyout  output  1  slave ready
hresp  output  1  0 OKAY, 1 ERROR

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, state IDLE, latched phase regs cleared. RAM contents not reset. Reset mid-transfer aborts the transfer; a pending write is discarded.
- Address phase accepted when hsel && htrans[1] && hready. It latches haddr, hwrite, hsize and error flag. Otherwise (IDLE/BUSY/unselected) the block returns zero-wait OKAY.
- Error if any of the following: haddr[31:24] != BASE_TAG; offset bits haddr[23:ADDR_WIDTH+2] nonzero; hsize > 3'b010; half with haddr[0]=1; word with haddr[1:0] != 0.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on accepted legal transfer, go to WAIT if WAIT_STATES>0 (hreadyout=0), else complete next cycle with hreadyout=1. On accepted error transfer, go to ERR1.
  - WAIT: wait counter counts WAIT_STATES cycles with hreadyout=0, hresp=0. The last data-phase cycle has hreadyout=1.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1 → IDLE. No RAM access for an errored transfer.
- Latency: data phase length = WAIT_STATES+1 cycles for OKAY, exactly 2 cycles for ERROR.
- Write: lanes from latched haddr[1:0]/hsize:
  - byte → lane haddr[1:0]
  - half → lanes {haddr[1],0} and {haddr[1],1}
  - word → all 4 lanes
  - hwdata is sampled and RAM updated on the edge ending the final data-phase cycle (hreadyout=1). Unselected lanes are unchanged.
- Read: hrdata = RAM[latched word addr] during the completion cycle. It is 0 in all other cycles.
- Pipelining: a new address phase may be accepted in the same cycle the previous data phase completes (hready=1). Back-to-back transfers are sustained at WAIT_STATES+1 cycles each. Read after write to the same word returns the new data.
- Address phase seen while hreadyout=0: ignored, because the bus hready is low.

Optional Feature:
PROT_CHECK_EN: when defined, an accepted transfer with hprot[0]=0 (opcode fetch) is also flagged as an error → two-cycle ERROR, no RAM access. When undefined, hprot is ignored.

Test Plan:
- Word write then read, WAIT_STATES=1: write 32'hDEADBEEF @ 32'hB000_0010, then read same address → hreadyout low 1 cycle each; read hrdata=32'hDEADBEEF, hresp=0.
- Byte/half lanes: word write 0 @B000_0020, SB 8'hAA @B000_0022, SH 16'h1234 @B000_0020 → word read = 32'h00AA_1234.
- Misaligned: LW @B000_0002 and LH @B000_0001 → hresp=1 for 2 cycles (hreadyout 0 then 1); RAM word unchanged.
- Out-of-range: read @A000_0000, and read @B000_1000 with ADDR_WIDTH=10 → ERROR response, hrdata=0.
- Pipelined back-to-back, WAIT_STATES=0: NONSEQ writes @B000_0000..000C on consecutive cycles, then reads → 1 transfer/cycle, data matches; IDLE/BUSY cycles give hreadyout=1, hresp=0.
- Reset mid-write: assert hreset during the WAIT cycle of a write 32'h55 @B000_0030 → outputs at reset values next cycle; later read returns the prior contents.
